// File: rtl/stopwatch_bcd_if.sv
// Pulse/display bundle between the tick source, stopwatch_bcd and the display stage.
// master drives the control pulses; slave is the stopwatch itself.
interface stopwatch_bcd_if;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [23:0] digits;
    logic        running;
    logic        lap_held;
    logic        overflow;

    modport master (
        output tick, start_stop, clear, lap,
        input  digits, running, lap_held, overflow
    );

    modport slave (
        input  tick, start_stop, clear, lap,
        output digits, running, lap_held, overflow
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// Tick-prescaled BCD stopwatch (mm:ss.cc) with start/stop/clear and optional lap hold.
// Lap support is built only when STOPWATCH_LAP_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | cleared, not counting, waiting for start_stop
// ST_RUN    | counting ticks, live count displayed
// ST_PAUSED | count frozen, prescaler phase kept for resume
// ST_LAP    | counting continues, lap register displayed
module stopwatch_bcd #(
    parameter int unsigned TICKS_PER_UNIT = 1
) (
    input logic            clk,
    input logic            rst,
    stopwatch_bcd_if.slave sw
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_LAP    = 2'd3
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_UNIT - 1);

    state_t      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [23:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [23:0] digits_q, digits_d;
    logic        running_q, running_d;
    logic [24:0] inc;
    logic        counting;

`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_q, lap_d;
    logic        lap_held_q, lap_held_d;
`else
    logic        unused_lap;
    assign unused_lap = sw.lap;
`endif

    // One centisecond step through the six digits; bit 24 is the 59:59.99 wrap.
    // The >= keeps a digit in range even if it ever held an illegal code.
    function automatic logic [24:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        logic [3:0]  d;
        logic [3:0]  lim;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = v[4*i +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (d >= lim) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
`ifdef STOPWATCH_LAP_EN
        lap_d    = lap_q;
`endif
        inc      = bcd_inc(cnt_q);
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);

        // Counting looks at the current state, so a tick alongside start_stop
        // is taken in RUN but not in PAUSED.
        if (counting && sw.tick) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                cnt_d = inc[23:0];
                if (inc[24]) begin
                    ovf_d = 1'b1;
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end

        if (sw.clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_d   = '0;
`endif
        end else if (sw.start_stop) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    pre_d   = '0;
                end
                ST_RUN:    state_d = ST_PAUSED;
                ST_LAP:    state_d = ST_PAUSED;
                ST_PAUSED: state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
`ifdef STOPWATCH_LAP_EN
        else if (sw.lap) begin
            // Capture the pre-increment value seen on this edge.
            if (state_q == ST_RUN) begin
                state_d = ST_LAP;
                lap_d   = cnt_q;
            end else if (state_q == ST_LAP) begin
                state_d = ST_RUN;
            end
        end
`endif

        running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
`ifdef STOPWATCH_LAP_EN
        lap_held_d = (state_d == ST_LAP);
        digits_d   = lap_held_d ? lap_d : cnt_d;
`else
        digits_d   = cnt_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            running_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_q      <= '0;
            lap_held_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            running_q  <= running_d;
`ifdef STOPWATCH_LAP_EN
            lap_q      <= lap_d;
            lap_held_q <= lap_held_d;
`endif
        end
    end

    assign sw.digits   = digits_q;
    assign sw.running  = running_q;
    assign sw.overflow = ovf_q;
`ifdef STOPWATCH_LAP_EN
    assign sw.lap_held = lap_held_q;
`else
    assign sw.lap_held = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: a per-cycle vector table plus hand sequences
// for counting, prescaling, carries/wrap, lap hold, collisions and async reset.
`timescale 1ns/1ps
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stopwatch_bcd_if sw1 ();
    stopwatch_bcd_if sw4 ();

    stopwatch_bcd #(.TICKS_PER_UNIT(1)) u_dut1 (.clk(clk), .rst(rst), .sw(sw1));
    stopwatch_bcd #(.TICKS_PER_UNIT(4)) u_dut4 (.clk(clk), .rst(rst), .sw(sw4));

    typedef struct {
        string       name;
        logic        tick;
        logic        ss;
        logic        clr;
        logic        lap;
        logic [23:0] digits;
        logic        running;
        logic        lap_held;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vec [NVEC];

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] preload_val = '0;

    function automatic logic [26:0] obs1();
        return {sw1.digits, sw1.running, sw1.lap_held, sw1.overflow};
    endfunction

    function automatic logic [26:0] obs4();
        return {sw4.digits, sw4.running, sw4.lap_held, sw4.overflow};
    endfunction

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got digits=%h running=%b lap_held=%b overflow=%b, expected digits=%h running=%b lap_held=%b overflow=%b",
                     name, act[26:3], act[2], act[1], act[0], exp[26:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic set_vec(input int i, input string n, input logic t, input logic ss,
                           input logic cl, input logic lp, input logic [23:0] d,
                           input logic r, input logic lh, input logic o);
        vec[i].name = n;   vec[i].tick = t;    vec[i].ss = ss;       vec[i].clr = cl;
        vec[i].lap = lp;   vec[i].digits = d;  vec[i].running = r;   vec[i].lap_held = lh;
        vec[i].ovf = o;
    endtask

    // Called at a negedge: drive for one posedge, release at the following negedge.
    task automatic step1(input logic t, input logic ss, input logic cl, input logic lp);
        sw1.tick = t; sw1.start_stop = ss; sw1.clear = cl; sw1.lap = lp;
        @(negedge clk);
        sw1.tick = 1'b0; sw1.start_stop = 1'b0; sw1.clear = 1'b0; sw1.lap = 1'b0;
    endtask

    task automatic step4(input logic t, input logic ss, input logic cl, input logic lp);
        sw4.tick = t; sw4.start_stop = ss; sw4.clear = cl; sw4.lap = lp;
        @(negedge clk);
        sw4.tick = 1'b0; sw4.start_stop = 1'b0; sw4.clear = 1'b0; sw4.lap = 1'b0;
    endtask

    task automatic ticks1(input int n);
        for (int k = 0; k < n; k++) step1(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks4(input int n);
        for (int k = 0; k < n; k++) step4(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Jump the live count of the TICKS_PER_UNIT=1 instance (must be idle-input cycle).
    task preload1(input logic [23:0] v);
        preload_val = v;
        force u_dut1.cnt_q = preload_val;
        @(negedge clk);
        release u_dut1.cnt_q;
    endtask

    initial begin
        sw1.tick = 1'b0; sw1.start_stop = 1'b0; sw1.clear = 1'b0; sw1.lap = 1'b0;
        sw4.tick = 1'b0; sw4.start_stop = 1'b0; sw4.clear = 1'b0; sw4.lap = 1'b0;

        //          idx name                tick ss clr lap digits                          run lh                 ovf
        set_vec( 0, "idle_quiet",           0, 0, 0, 0, 24'h000000,                     0, 0,                 0);
        set_vec( 1, "idle_tick_ignored",    1, 0, 0, 0, 24'h000000,                     0, 0,                 0);
        set_vec( 2, "idle_lap_ignored",     0, 0, 0, 1, 24'h000000,                     0, 0,                 0);
        set_vec( 3, "start",                0, 1, 0, 0, 24'h000000,                     1, 0,                 0);
        set_vec( 4, "run_tick1",            1, 0, 0, 0, 24'h000001,                     1, 0,                 0);
        set_vec( 5, "run_tick2",            1, 0, 0, 0, 24'h000002,                     1, 0,                 0);
        set_vec( 6, "tick_with_lap",        1, 0, 0, 1, LAP_EN ? 24'h000002 : 24'h000003, 1, LAP_EN,          0);
        set_vec( 7, "tick_in_lap",          1, 0, 0, 0, LAP_EN ? 24'h000002 : 24'h000004, 1, LAP_EN,          0);
        set_vec( 8, "lap_release",          0, 0, 0, 1, 24'h000004,                     1, 0,                 0);
        set_vec( 9, "run_tick_and_stop",    1, 1, 0, 0, 24'h000005,                     0, 0,                 0);
        set_vec(10, "paused_tick",          1, 0, 0, 0, 24'h000005,                     0, 0,                 0);
        set_vec(11, "paused_lap_ignored",   0, 0, 0, 1, 24'h000005,                     0, 0,                 0);
        set_vec(12, "paused_tick_and_go",   1, 1, 0, 0, 24'h000005,                     1, 0,                 0);
        set_vec(13, "stop_beats_lap",       0, 1, 0, 1, 24'h000005,                     0, 0,                 0);
        set_vec(14, "resume",               0, 1, 0, 0, 24'h000005,                     1, 0,                 0);
        set_vec(15, "tick_and_clear",       1, 0, 1, 0, 24'h000000,                     0, 0,                 0);
        set_vec(16, "clear_beats_start",    0, 1, 1, 0, 24'h000000,                     0, 0,                 0);
        set_vec(17, "idle_after_clear",     1, 0, 0, 0, 24'h000000,                     0, 0,                 0);

        repeat (2) @(negedge clk);
        chk("reset_dut1", obs1(), 27'h0);
        chk("reset_dut4", obs4(), 27'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            step1(vec[i].tick, vec[i].ss, vec[i].clr, vec[i].lap);
            chk(vec[i].name, obs1(), {vec[i].digits, vec[i].running, vec[i].lap_held, vec[i].ovf});
        end

        // Basic count then carries through each digit boundary and the wrap.
        step1(1'b0, 1'b1, 1'b0, 1'b0);
        ticks1(100);
        chk("count_100", obs1(), {24'h000100, 3'b100});
        preload1(24'h000999);
        ticks1(1);
        chk("carry_s1", obs1(), {24'h001000, 3'b100});
        preload1(24'h005999);
        ticks1(1);
        chk("carry_m0", obs1(), {24'h010000, 3'b100});
        preload1(24'h095999);
        ticks1(1);
        chk("carry_m1", obs1(), {24'h100000, 3'b100});
        preload1(24'h595999);
        ticks1(1);
        chk("wrap", obs1(), {24'h000000, 3'b101});
        ticks1(1);
        chk("overflow_sticky", obs1(), {24'h000001, 3'b101});
        step1(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_after_wrap", obs1(), {24'h000000, 3'b000});
        ticks1(1);
        chk("idle_after_wrap_clear", obs1(), {24'h000000, 3'b000});

        // Prescaler of 4 on the second instance.
        step4(1'b0, 1'b1, 1'b0, 1'b0);
        ticks4(10);
        chk("pre4_10_ticks", obs4(), {24'h000002, 3'b100});
        step4(1'b0, 1'b1, 1'b0, 1'b0);
        ticks4(3);
        chk("pre4_paused", obs4(), {24'h000002, 3'b000});
        step4(1'b0, 1'b1, 1'b0, 1'b0);
        ticks4(2);
        chk("pre4_resume_kept_phase", obs4(), {24'h000003, 3'b100});
        ticks4(3);
        chk("pre4_partial", obs4(), {24'h000003, 3'b100});
        ticks4(1);
        chk("pre4_next_unit", obs4(), {24'h000004, 3'b100});

        // Lap hold.
        step1(1'b0, 1'b1, 1'b0, 1'b0);
        ticks1(50);
        chk("lap_pre", obs1(), {24'h000050, 3'b100});
`ifdef STOPWATCH_LAP_EN
        step1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_capture", obs1(), {24'h000050, 3'b110});
        ticks1(30);
        chk("lap_frozen", obs1(), {24'h000050, 3'b110});
        step1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_release_live", obs1(), {24'h000080, 3'b100});
        step1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_again", obs1(), {24'h000080, 3'b110});
`else
        step1(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_ignored", obs1(), {24'h000050, 3'b100});
        ticks1(30);
        chk("lap_ignored_live", obs1(), {24'h000080, 3'b100});
`endif
        step1(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tick_stop_from_lap_or_run", obs1(), {24'h000081, 3'b000});

        // Collisions at 00:00.07.
        step1(1'b0, 1'b0, 1'b1, 1'b0);
        step1(1'b0, 1'b1, 1'b0, 1'b0);
        ticks1(7);
        chk("coll_pre", obs1(), {24'h000007, 3'b100});
        step1(1'b1, 1'b1, 1'b0, 1'b0);
        chk("coll_tick_stop", obs1(), {24'h000008, 3'b000});
        step1(1'b0, 1'b1, 1'b0, 1'b0);
        step1(1'b1, 1'b0, 1'b1, 1'b0);
        chk("coll_tick_clear", obs1(), {24'h000000, 3'b000});
        ticks1(1);
        chk("coll_idle", obs1(), {24'h000000, 3'b000});

        // Async reset between edges while counting.
        step1(1'b0, 1'b1, 1'b0, 1'b0);
        ticks1(37);
        chk("async_pre", obs1(), {24'h000037, 3'b100});
        sw1.tick = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_dut1", obs1(), 27'h0);
        chk("async_dut4", obs4(), 27'h0);
        @(negedge clk);
        sw1.tick = 1'b0;
        rst = 1'b1;
        ticks1(1);
        chk("after_reset_idle", obs1(), 27'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Tick-driven BCD stopwatch that sits directly downstream of `Ticker`. It consumes the one-cycle `tick` pulse, prescales it, and counts minutes, seconds and centiseconds in BCD for the display stage. A start/stop/clear/lap control state machine sits inside `Top` between `Ticker` and the display driver.

## Interface
- `TICKS_PER_UNIT`, default 1: number of `tick` pulses per centisecond increment; legal range 1..65535.
- `clk`  input  1  system clock (fpga_clk).
- `rst`  input  1  asynchronous, active-low reset; the block is in reset while `rst` = 0.
- `tick`  input  1  one-cycle pulse from `Ticker`, synchronous to `clk`.
- `start_stop`  input  1  one-cycle pulse; toggles between running and paused.
- `clear`  input  1  one-cycle pulse; zeroes the count and returns to IDLE.
- `lap`  input  1  one-cycle pulse; freezes or releases the displayed value.
- `digits`  output  24  BCD value {m1,m0,s1,s0,c1,c0}, 4 bits per digit, m1 in [23:20].
- `running`  output  1  high in RUN and LAP.
- `lap_held`  output  1  high in LAP.
- `overflow`  output  1  sticky wrap flag.

## Operation
- Reset values: `digits` = 24'h000000, `running` = 0, `lap_held` = 0, `overflow` = 0, state IDLE, prescaler 0, lap register 0.
- State machine states: IDLE, RUN, PAUSED, LAP.
- Transitions:
  - IDLE, on `start_stop` -> RUN; prescaler cleared.
  - RUN, on `start_stop` -> PAUSED.
  - PAUSED, on `start_stop` -> RUN; prescaler is kept.
  - RUN, on `lap` -> LAP; the live count is copied into the lap register.
  - LAP, on `lap` -> RUN.
  - LAP, on `start_stop` -> PAUSED; the lap is released.
  - any state, on `clear` -> IDLE; count, prescaler, lap register and `overflow` are all zeroed.
- `lap` in IDLE or PAUSED is ignored.
- Priority when pulses coincide in one cycle: `clear` > `start_stop` > `lap`.
- Counting happens only in RUN or LAP, on cycles with `tick` = 1:
  - If prescaler = `TICKS_PER_UNIT`-1, the prescaler returns to 0 and the count increments by 0.01 s.
  - Otherwise the prescaler increments.
- BCD carry chain:
  - c0 9 -> 0 carries to c1; c1 9 -> 0 carries to s0.
  - s0 9 -> 0 carries to s1; s1 5 -> 0 carries to m0.
  - m0 9 -> 0 carries to m1; m1 5 -> 0 is the wrap.
  - No digit may ever hold a value above 9, and s1/m1 may never exceed 5.
- Wrap: 59:59.99 plus one increment -> 00:00.00, and `overflow` is set. `overflow` stays set until `clear` or reset.
- Display select: `digits` shows the lap register in LAP and the live count in every other state. The live count keeps advancing while in LAP.
- Simultaneous events:
  - `tick` and `start_stop` in the same cycle in RUN: the tick is counted, then the state goes to PAUSED.
  - `tick` and `start_stop` in the same cycle in PAUSED: the tick is not counted.
  - `tick` and `clear` in the same cycle: the clear wins and the result is 00:00.00.
- Reset asserted mid-count: all state and outputs reach their reset values immediately (asynchronously), regardless of `clk`.

## Timing
- All outputs are registered.
- `digits` reflects an increment on the first `clk` edge after the sampled `tick`, i.e. 1-cycle latency.
- State changes and `running`/`lap_held` update on the edge that samples the control pulse, i.e. 1-cycle latency.
- The lap capture takes the live value present on the same edge, so an increment happening on that edge is not included.
- Inputs are sampled on the rising edge only. No pulse-width checking is done; a level held for N cycles acts as N pulses.
- Deassertion of `rst` is taken synchronous to `clk` by the upstream reset logic; this block does not resynchronise it.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined: the LAP state, the lap register and `lap_held` are implemented as described above.
- Undefined:
  - LAP state and lap register are not built.
  - `lap` input is ignored.
  - `lap_held` is tied to 0.
  - `digits` always shows the live count.
  - All other behaviour is unchanged.

## Test plan
- Reset and basic count (`TICKS_PER_UNIT`=1): reset, pulse `start_stop`, apply 100 ticks -> `digits` = 24'h000100 (00:01.00), `running` = 1.
- Prescaler (`TICKS_PER_UNIT`=4): apply 10 ticks in RUN -> 24'h000002; pause; apply 3 ticks -> value unchanged; resume; apply 2 ticks -> 24'h000003.
- Wrap: count up to 24'h595999, then apply 1 tick -> 24'h000000 with `overflow` = 1; pulse `clear` -> `overflow` = 0 and state IDLE.
- Lap (macro defined): at 24'h000050 pulse `lap`, then apply 30 ticks -> `digits` holds 24'h000050 and `lap_held` = 1; pulse `lap` again -> `digits` = 24'h000080.
- Collisions: `tick` and `start_stop` together in RUN at 24'h000007 -> 24'h000008 and state PAUSED; `tick` and `clear` together -> 24'h000000 and state IDLE.
- Async reset: drive `rst` low between clock edges while counting -> every output goes to zero before the next `clk` edge.
